shift_add_mul_ctrl: RTL and testbench

//  Sequential unsigned N x N -> 2N multiplier built around one shared N-bit ripple adder.
//  FSM sequences shift-and-add: one multiplier bit per cycle; adder reused every cycle.

---
 rtl/shift_add_mul_ctrl_pkg.sv | 15 +
 rtl/shift_add_mul_ctrl_if.sv | 14 +
 rtl/shift_add_mul_ctrl_nibble_adder.sv | 24 ++
 rtl/shift_add_mul_ctrl.sv | 152 +++++++++++++++
 tb/tb_shift_add_mul_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/shift_add_mul_ctrl_pkg.sv
// Shared types for the shift-and-add multiplier: FSM encodings and counter sizing.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter must hold 0..N without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/shift_add_mul_ctrl_if.sv
// Requester-side handshake and result bus of the shift-and-add multiplier.
interface shift_add_mul_ctrl_if #(
  parameter int N = 4
);
  logic             start;
  logic [N-1:0]     A;
  logic [N-1:0]     B;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   P;

  modport master (output start, A, B, input busy, done, P);
  modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/shift_add_mul_ctrl_nibble_adder.sv
// N-bit ripple-carry adder; the single arithmetic resource shared by every iteration.
module nibble_adder #(
  parameter int N = 4
) (
  input  logic         cin,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s,
  output logic         cout
);

  // Ripple carry from bit 0 upward.
  always_comb begin : p_ripple
    logic carry_v;
    carry_v = cin;
    s       = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      s[i]    = x[i] ^ y[i] ^ carry_v;
      carry_v = (x[i] & y[i]) | (carry_v & (x[i] ^ y[i]));
    end
    cout = carry_v;
  end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential unsigned N x N -> 2N multiplier, one multiplier bit per cycle.
// Optional early termination on exhausted multiplier bits: define MUL_ZERO_SKIP_EN.
module shift_add_mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input logic                Clock,
  input logic                Resetn,
  shift_add_mul_ctrl_if.slave bus
);

  localparam int CW = cnt_width(N);

  state_t          state_r;
  state_t          state_next_s;
  logic [N-1:0]    m_r;
  logic [N-1:0]    q_r;
  logic [N-1:0]    acc_r;
  logic            c_r;
  logic [CW-1:0]   cnt_r;
  logic [2*N-1:0]  p_r;
  logic            busy_r;
  logic            done_r;

  logic [N-1:0]    addend_s;
  logic [N-1:0]    sum_s;
  logic            cout_s;
  logic [2*N:0]    shifted_s;
  logic            last_s;
  logic            skip_s;
  logic [2*N-1:0]  p_next_s;
  logic            busy_s;
  logic            done_s;

  nibble_adder #(.N(N)) u_adder (
    .cin  (1'b0),
    .x    (acc_r),
    .y    (addend_s),
    .s    (sum_s),
    .cout (cout_s)
  );

  // Add-then-shift step; C is zero after every shift, so OR-ing it in only keeps the carry path explicit.
  always_comb begin
    addend_s  = q_r[0] ? m_r : {N{1'b0}};
    shifted_s = {(cout_s | c_r), sum_s, q_r} >> 1;
    last_s    = (cnt_r == CW'(N - 1));
  end

`ifdef MUL_ZERO_SKIP_EN
  logic [N-1:0] mask_s;

  // Finish early once the unconsumed multiplier bits are all zero.
  always_comb begin
    mask_s = ~({N{1'b1}} << (N - int'(cnt_r)));
    if ((q_r & mask_s) == {N{1'b0}}) begin
      skip_s   = 1'b1;
      p_next_s = {acc_r, q_r} >> (N - int'(cnt_r));
    end else begin
      skip_s   = 1'b0;
      p_next_s = shifted_s[2*N-1:0];
    end
  end
`else
  // Fixed-length run: the product is always the post-shift register pair.
  always_comb begin
    skip_s   = 1'b0;
    p_next_s = shifted_s[2*N-1:0];
  end
`endif

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: state_next_s = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_next_s = (skip_s || last_s) ? ST_DONE : ST_RUN;
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done come straight from flops.
  always_comb begin
    busy_s = (state_next_s == ST_RUN) || (state_next_s == ST_DONE);
    done_s = (state_next_s == ST_DONE);
  end

  // Registered status outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Operand capture, iteration datapath and product register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_r   <= {N{1'b0}};
      q_r   <= {N{1'b0}};
      acc_r <= {N{1'b0}};
      c_r   <= 1'b0;
      cnt_r <= {CW{1'b0}};
      p_r   <= {(2*N){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            m_r   <= bus.A;
            q_r   <= bus.B;
            acc_r <= {N{1'b0}};
            c_r   <= 1'b0;
            cnt_r <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          if (skip_s) begin
            p_r <= p_next_s;
          end else begin
            c_r   <= shifted_s[2*N];
            acc_r <= shifted_s[2*N-1:N];
            q_r   <= shifted_s[N-1:0];
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (last_s) begin
              p_r <= p_next_s;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.P    = p_r;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Scoreboard bench for shift_add_mul_ctrl; expected products queued at start, checked on done.
module tb_shift_add_mul_ctrl;

  localparam int N = 4;

  logic Clock;
  logic Resetn;

  shift_add_mul_ctrl_if #(.N(N)) bus ();

  shift_add_mul_ctrl #(.N(N)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  int             n_total = 0;
  int             n_bad   = 0;
  logic [2*N-1:0] sb_q[$];
  int             cyc = 0;
  int             last_done_cyc = 0;
  int             done_gap = 0;
  bit             prev_done = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle of done relative to the accepting edge.
  function automatic int exp_lat(input logic [N-1:0] b);
`ifdef MUL_ZERO_SKIP_EN
    int idx;
    if (b == {N{1'b0}}) return 1;
    idx = 0;
    for (int i = 0; i < N; i++) if (b[i]) idx = i;
    return (idx + 2 > N) ? N : idx + 2;
`else
    return N;
`endif
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest queued product.
  always @(negedge Clock) begin
    cyc++;
    if (bus.done) begin
      check_val("done_single", 32'(prev_done), 32'd0);
      done_gap      = cyc - last_done_cyc;
      last_done_cyc = cyc;
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        check_val("product", 32'(bus.P), 32'(sb_q.pop_front()));
      end
    end
    prev_done = bus.done;
  end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit pester);
    int lat;
    int busy_n;
    bit got;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    sb_q.push_back({{N{1'b0}}, a} * {{N{1'b0}}, b});
    @(posedge Clock);
    @(negedge Clock);
    busy_n    = bus.busy ? 1 : 0;
    bus.A     = N'($urandom_range(0, (1 << N) - 1));
    bus.B     = N'($urandom_range(0, (1 << N) - 1));
    bus.start = pester;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge Clock);
      lat++;
      @(negedge Clock);
      if (bus.busy) busy_n++;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    check_val("latency", 32'(lat), 32'(exp_lat(b)));
    check_val("busy_cycles", 32'(busy_n), 32'(lat + 1));
    @(negedge Clock);
    check_val("idle_after", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clock);
      if (bus.done) got = 1'b1;
    end
    check_val(tag, 32'(got), 32'd1);
  endtask

  initial begin
    Resetn    = 1'b0;
    bus.start = 1'b1;
    bus.A     = 4'd5;
    bus.B     = 4'd5;

    // Reset held with start asserted: nothing moves.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      check_val("rst_p", 32'(bus.P), 32'd0);
    end
    bus.start = 1'b0;
    Resetn    = 1'b1;
    @(negedge Clock);

    run_op(4'd13, 4'd11, 1'b0);
    check_val("p_hold_143", 32'(bus.P), 32'd143);

    run_op(4'd15, 4'd15, 1'b0);
    run_op(4'd0,  4'd9,  1'b0);
    run_op(4'd5,  4'd0,  1'b0);
    run_op(4'd7,  4'd1,  1'b0);
    check_val("p_hold_7", 32'(bus.P), 32'd7);

    // Start re-asserted through the run with other operands: ignored.
    run_op(4'd10, 4'd12, 1'b1);
    repeat (6) @(negedge Clock);
    check_val("pester_p", 32'(bus.P), 32'd120);

    // Back-to-back with start held high.
    bus.A     = 4'd3;
    bus.B     = 4'd5;
    bus.start = 1'b1;
    sb_q.push_back(8'd15);
    wait_done("b2b_first");
    bus.A = 4'd6;
    bus.B = 4'd2;
    sb_q.push_back(8'd12);
    wait_done("b2b_second");
    bus.start = 1'b0;
    @(negedge Clock);
    check_val("b2b_gap", 32'((done_gap >= N + 1) && (done_gap <= N + 2)), 32'd1);
    check_val("b2b_p", 32'(bus.P), 32'd12);
    repeat (6) @(negedge Clock);

    // Reset in the middle of a run aborts it without a done pulse.
    bus.A     = 4'd13;
    bus.B     = 4'd11;
    bus.start = 1'b1;
    @(posedge Clock);
    #1 bus.start = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #1 Resetn = 1'b0;
    @(negedge Clock);
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_p", 32'(bus.P), 32'd0);
    Resetn = 1'b1;
    repeat (6) @(negedge Clock);
    check_val("abort_p_hold", 32'(bus.P), 32'd0);
    check_val("abort_idle", 32'(bus.busy), 32'd0);
    run_op(4'd9, 4'd9, 1'b0);
    check_val("after_abort_p", 32'(bus.P), 32'd81);

    // Random operands against the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      run_op(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)), 1'b0);
    end

    repeat (4) @(negedge Clock);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
